// File: rtl/snn_readout_pkg.sv
// Shared definitions for the spike readout block: FSM state encoding,
// winner codes and default widths.
package snn_readout_pkg;

   localparam int CNT_W_DEF = 8;
   localparam int WIN_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_A    = 2'b01;
   localparam logic [1:0] WIN_B    = 2'b10;
   localparam logic [1:0] WIN_TIE  = 2'b11;

endpackage

// File: rtl/sat_spike_counter.sv
// Saturating spike counter: clears on request, counts enabled high spikes
// and sticks at all-ones instead of wrapping.
module sat_spike_counter
   import snn_readout_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic             spike,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] count_next
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (&c)
         return c;
      else
         return c + CNT_W'(1);
   endfunction

   // count_next is exported so the parent can register a decision that
   // already includes the spike sampled on the final window cycle.
   always_comb begin
      count_next = count;
      if (clear)
         count_next = '0;
      else if (enable && spike)
         count_next = sat_inc(count);
   end

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else
         count <= count_next;
   end

endmodule

// File: rtl/spike_readout.sv
// Output-layer readout: counts spikes of two output neurons over a window,
// then holds the counts and a registered winner until the consumer accepts.
module spike_readout
   import snn_readout_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int WIN_W = WIN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIN_W-1:0] window_len,
   input  logic             spike_a,
   input  logic             spike_b,
   output logic             busy,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [CNT_W-1:0] count_a,
   output logic [CNT_W-1:0] count_b,
   output logic [1:0]       winner
);

   state_t           state, state_nx;
   logic [WIN_W-1:0] len_q;
   logic [WIN_W-1:0] win_cnt;
   logic             accept;
   logic             last_cycle;
   logic             counting;
   logic [CNT_W-1:0] count_a_nx, count_b_nx;

   function automatic logic [1:0] pick_winner(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
      if (a == '0 && b == '0)
         return WIN_NONE;
      else if (a == b)
         return WIN_TIE;
      else if (a > b)
         return WIN_A;
      else
         return WIN_B;
   endfunction

   assign accept     = (state == IDLE) && start && (window_len != '0);
   assign counting   = (state == COUNT);
   assign last_cycle = counting && (win_cnt == len_q - WIN_W'(1));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept)       state_nx = COUNT;
         COUNT:   if (last_cycle)   state_nx = HOLD;
         HOLD:    if (result_ready) state_nx = IDLE;
         default:                   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // The latched length isolates the window from later window_len changes.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q   <= '0;
         win_cnt <= '0;
      end else if (accept) begin
         len_q   <= window_len;
         win_cnt <= '0;
      end else if (counting) begin
         win_cnt <= win_cnt + WIN_W'(1);
      end
   end

   sat_spike_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .clk        (clk),
      .rst        (rst),
      .clear      (accept),
      .enable     (counting),
      .spike      (spike_a),
      .count      (count_a),
      .count_next (count_a_nx)
   );

   sat_spike_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .clk        (clk),
      .rst        (rst),
      .clear      (accept),
      .enable     (counting),
      .spike      (spike_b),
      .count      (count_b),
      .count_next (count_b_nx)
   );

   always_ff @(posedge clk) begin
      if (rst || accept)
         winner <= WIN_NONE;
      else if (last_cycle)
         winner <= pick_winner(count_a_nx, count_b_nx);
   end

   assign busy         = (state != IDLE);
   assign result_valid = (state == HOLD);

endmodule
